// File: rtl/dbus_burst_arbiter.sv
// Round-robin burst arbiter sharing the ext_mem DMA databus among N_MASTERS requesters.
// Optional `DBUS_ARB_PRIO_EN: requester 0 gets fixed top priority when idle.
module dbus_burst_arbiter #(
  parameter int N_MASTERS = 3,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 256,
  parameter int LEN_W     = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [N_MASTERS-1:0]            m_valid,
  input  logic [N_MASTERS*ADDR_W-1:0]     m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]     m_wdata,
  input  logic [N_MASTERS*DATA_W/8-1:0]   m_wstrb,
  input  logic [N_MASTERS*LEN_W-1:0]      m_len,
  output logic [DATA_W-1:0]               m_rdata,
  output logic [N_MASTERS-1:0]            m_ready,
  output logic                            s_valid,
  output logic [ADDR_W-1:0]               s_addr,
  output logic [DATA_W-1:0]               s_wdata,
  output logic [DATA_W/8-1:0]             s_wstrb,
  output logic [LEN_W-1:0]                s_len,
  input  logic [DATA_W-1:0]               s_rdata,
  input  logic                            s_ready,
  output logic [N_MASTERS-1:0]            grant,
  output logic                            busy
);

  localparam int SW = DATA_W / 8;
  localparam int IW = $clog2(N_MASTERS);

  typedef enum logic [0:0] {IDLE, XFER} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        sel_q, sel_d;
  logic [IW-1:0]        rr_q, rr_d;
  logic [N_MASTERS-1:0] grant_q, grant_d;
  logic [LEN_W-1:0]     beat_q, beat_d;
  logic [LEN_W-1:0]     len_q, len_d;

  logic [IW-1:0] pick;
  logic          found;
  logic          beat;

  // Scan from rr_q upward with wrap; first valid requester wins.
  always_comb begin
    pick  = '0;
    found = 1'b0;
`ifdef DBUS_ARB_PRIO_EN
    if (m_valid[0]) begin
      pick  = '0;
      found = 1'b1;
    end
`endif
    for (int i = 0; i < N_MASTERS; i++) begin
      int idx;
      idx = (int'(rr_q) + i) % N_MASTERS;
`ifdef DBUS_ARB_PRIO_EN
      if (!found && idx != 0 && m_valid[idx]) begin
`else
      if (!found && m_valid[idx]) begin
`endif
        pick  = IW'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    m_rdata = s_rdata;
    m_ready = '0;
    s_valid = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    s_wstrb = '0;
    s_len   = '0;
    if (state_q == XFER) begin
      s_valid        = m_valid[sel_q];
      s_addr         = m_addr[sel_q*ADDR_W +: ADDR_W];
      s_wdata        = m_wdata[sel_q*DATA_W +: DATA_W];
      s_wstrb        = m_wstrb[sel_q*SW +: SW];
      s_len          = len_q;
      m_ready[sel_q] = s_ready;
    end
  end

  assign beat  = s_valid & s_ready;
  assign grant = grant_q;
  assign busy  = (state_q == XFER);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    beat_d  = beat_q;
    len_d   = len_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = XFER;
          sel_d   = pick;
          grant_d = N_MASTERS'(1) << pick;
          len_d   = m_len[pick*LEN_W +: LEN_W];
          beat_d  = '0;
        end
      end
      XFER: begin
        if (beat) begin
          if (beat_q == len_q) begin
            state_d = IDLE;
            grant_d = '0;
            rr_d    = (sel_q == IW'(N_MASTERS-1)) ? '0 : sel_q + 1'b1;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      rr_q    <= '0;
      grant_q <= '0;
      beat_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
    end
  end

endmodule

// File: tb/tb_dbus_burst_arbiter.sv
// Bench for dbus_burst_arbiter: burst-level reference model plus directed and random stimulus.
// Honours `DBUS_ARB_PRIO_EN in the model when the design is built with it.
module tb_dbus_burst_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 256;
  localparam int SW = DW / 8;
  localparam int LW = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      m_valid = '0;
  logic [N*AW-1:0]   m_addr = '0;
  logic [N*DW-1:0]   m_wdata = '0;
  logic [N*SW-1:0]   m_wstrb = '0;
  logic [N*LW-1:0]   m_len = '0;
  logic [DW-1:0]     m_rdata;
  logic [N-1:0]      m_ready;
  logic              s_valid;
  logic [AW-1:0]     s_addr;
  logic [DW-1:0]     s_wdata;
  logic [SW-1:0]     s_wstrb;
  logic [LW-1:0]     s_len;
  logic [DW-1:0]     s_rdata = '0;
  logic              s_ready = 1'b0;
  logic [N-1:0]      grant;
  logic              busy;

  int n_chk = 0;
  int n_fail = 0;

  dbus_burst_arbiter #(
    .N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_len(m_len),
    .m_rdata(m_rdata), .m_ready(m_ready),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_len(s_len),
    .s_rdata(s_rdata), .s_ready(s_ready),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: owner of the bus (-1 idle), beats done, burst length, next start.
  int  own = -1;
  int  done_beats = 0;
  int  blen = 0;
  int  rr = 0;
  bit  started = 0;

  function automatic int pick_req(logic [N-1:0] v, int start);
`ifdef DBUS_ARB_PRIO_EN
    if (v[0]) return 0;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (start + i) % N;
      if (k != 0 && v[k]) return k;
    end
`else
    for (int i = 0; i < N; i++) begin
      int k;
      k = (start + i) % N;
      if (v[k]) return k;
    end
`endif
    return -1;
  endfunction

  always @(posedge clk) begin
    int p;
    started = 1;
    if (!rst_n) begin
      own = -1;
      rr  = 0;
    end else if (own < 0) begin
      p = pick_req(m_valid, rr);
      if (p >= 0) begin
        own        = p;
        blen       = int'(m_len[p*LW +: LW]) + 1;
        done_beats = 0;
      end
    end else if (m_valid[own] && s_ready) begin
      done_beats++;
      if (done_beats == blen) begin
        rr  = (own + 1) % N;
        own = -1;
      end
    end
  end

  always @(negedge clk) begin
    logic [N-1:0]  eg, er;
    logic          ev;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [SW-1:0] es;
    logic [LW-1:0] el;
    if (started) begin
      eg = '0; er = '0; ev = 1'b0;
      ea = '0; ed = '0; es = '0; el = '0;
      if (own >= 0) begin
        eg[own] = 1'b1;
        er[own] = s_ready;
        ev = m_valid[own];
        ea = m_addr[own*AW +: AW];
        ed = m_wdata[own*DW +: DW];
        es = m_wstrb[own*SW +: SW];
        el = LW'(blen - 1);
      end
      chk("grant",   DW'(grant),   DW'(eg));
      chk("busy",    DW'(busy),    DW'(own >= 0));
      chk("s_valid", DW'(s_valid), DW'(ev));
      chk("s_addr",  DW'(s_addr),  DW'(ea));
      chk("s_wdata", s_wdata,      ed);
      chk("s_wstrb", DW'(s_wstrb), DW'(es));
      chk("s_len",   DW'(s_len),   DW'(el));
      chk("m_ready", DW'(m_ready), DW'(er));
      chk("m_rdata", m_rdata,      s_rdata);
    end
  end

  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 1'b0; m_valid = '0; s_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW/32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  initial begin
    int beats, got;
    logic [N-1:0] prev;
    logic [N-1:0] seen[$];
    logic [N-1:0] want[4];

    // Reset state
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_grant", DW'(grant), DW'(0));
    chk("reset_busy", DW'(busy), DW'(0));
    do_reset();

    // Single requester, len=3
    m_len[1*LW +: LW] = 8'd3;
    m_valid = 3'b010; s_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("t1_grant", DW'(grant), DW'(3'b010));
    beats = 0;
    for (int c = 0; c < 20; c++) begin
      if (grant == 3'b000) break;
      if (m_ready[1] && s_valid) beats++;
      @(negedge clk);
    end
    #1 m_valid = '0;
    chk("t1_beats", DW'(beats), DW'(4));

    // All three valid with len=0
    do_reset();
    m_len = '0; m_valid = 3'b111; s_ready = 1'b1;
    prev = '0;
    for (int c = 0; c < 40 && seen.size() < 4; c++) begin
      @(negedge clk);
      if (grant != 0 && prev == 0) seen.push_back(grant);
      prev = grant;
    end
    #1 m_valid = '0;
`ifdef DBUS_ARB_PRIO_EN
    want = '{3'b001, 3'b001, 3'b001, 3'b001};
`else
    want = '{3'b001, 3'b010, 3'b100, 3'b001};
`endif
    chk("t2_count", DW'(seen.size()), DW'(4));
    for (int i = 0; i < 4; i++)
      chk("t2_order", DW'(i < seen.size() ? seen[i] : 3'b000), DW'(want[i]));

    // Stall: len=7 with s_ready toggling
    do_reset();
    m_len[0 +: LW] = 8'd7; m_valid = 3'b001;
    beats = 0; got = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (c > 0 && grant == 0) break;
      if (grant != 0 && grant != 3'b001) got++;
      if (m_ready[2:1] != 0) got++;
      if (s_valid && s_ready) beats++;
      #1 s_ready = ~s_ready;
    end
    #1 m_valid = '0;
    chk("t3_beats", DW'(beats), DW'(8));
    chk("t3_held", DW'(got), DW'(0));

    // Valid gap on requester 2
    do_reset();
    m_len[2*LW +: LW] = 8'd2; m_valid = 3'b100; s_ready = 1'b1;
    beats = 0; got = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c > 0 && grant == 0) break;
      if (s_valid && s_ready) beats++;
      if (m_valid == 0 && (grant != 3'b100 || s_valid)) got++;
      #1;
      if (beats == 1 && m_valid != 0 && got == 0) begin
        m_valid = '0;
        repeat (4) @(negedge clk);
        if (grant != 3'b100 || s_valid) got++;
        #1 m_valid = 3'b100;
      end
    end
    #1 m_valid = '0;
    chk("t4_beats", DW'(beats), DW'(3));
    chk("t4_gap", DW'(got), DW'(0));

    // Reset mid-burst
    do_reset();
    m_len[0 +: LW] = 8'd5; m_valid = 3'b001; s_ready = 1'b1;
    beats = 0;
    for (int c = 0; c < 20 && beats < 2; c++) begin
      @(negedge clk);
      if (s_valid && s_ready) beats++;
    end
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("t5_grant", DW'(grant), DW'(0));
    chk("t5_busy", DW'(busy), DW'(0));
    chk("t5_valid", DW'(s_valid), DW'(0));
    #1 rst_n = 1'b1; m_valid = 3'b011; m_len = '0;
    @(negedge clk);
    chk("t5_rr", DW'(grant), DW'(3'b001));
    #1 m_valid = '0;

    // Random traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rst_n = ($urandom_range(0, 299) != 0);
      for (int m = 0; m < N; m++) begin
        m_valid[m] = ($urandom_range(0, 9) < 6);
        m_len[m*LW +: LW] = LW'($urandom_range(0, 4));
        m_addr[m*AW +: AW] = $urandom;
        m_wdata[m*DW +: DW] = rnd_word();
        m_wstrb[m*SW +: SW] = $urandom;
      end
      s_rdata = rnd_word();
      s_ready = ($urandom_range(0, 9) < 7);
    end
    @(negedge clk);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
